decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID pipeline stage of the RV32I core.
- Drives the register file read addresses from the fetched instruction and bypasses the same-cycle writeback, since the register file writes on the clock edge and a read in that cycle returns the old value.
- Decodes fields and immediates, detects load-use hazards, and registers everything into the ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage; the register file sits beside it.

Parameters:
WIDTH, 32, datapath and PC width
REGISTERS, 32, architectural register count (address width = $clog2(REGISTERS))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction from IF/ID
if_pc  in  WIDTH  PC of if_instr
rf_a1  out  $clog2(REGISTERS)  register file read address 1 = if_instr[19:15] (combinational)
rf_a2  out  $clog2(REGISTERS)  register file read address 2 = if_instr[24:20] (combinational)
rf_rd1  in  WIDTH  register file read data 1
rf_rd2  in  WIDTH  register file read data 2
wb_we  in  1  writeback enable (same signal as register file we3)
wb_rd  in  $clog2(REGISTERS)  writeback destination
wb_data  in  WIDTH  writeback data
ex_stall  in  1  execute stage cannot accept
flush  in  1  squash the instruction in ID (taken branch/jump)
id_stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  ID/EX contents valid
ex_pc  out  WIDTH  registered PC
ex_rs1_val  out  WIDTH  registered operand 1
ex_rs2_val  out  WIDTH  registered operand 2
ex_imm  out  WIDTH  registered sign-extended immediate
ex_rs1  out  $clog2(REGISTERS)  source 1 index, for forwarding
ex_rs2  out  $clog2(REGISTERS)  source 2 index, for forwarding
ex_rd  out  $clog2(REGISTERS)  destination index
ex_opcode  out  7  opcode
ex_funct3  out  3  funct3
ex_funct7b5  out  1  instr[30]
ex_is_load  out  1  opcode LOAD
ex_reg_write  out  1  instruction writes rd, and rd != 0

Behaviour:
- Reset: clock synchronous; all ex_* outputs = 0 (ex_valid = 0). id_stall is combinational, so it equals 0 while outputs are reset.
- Latency: one cycle from if_instr to ex_*.
- Operand select, per source s:
  - index 0 -> 0.
  - Otherwise, wb_we && wb_rd == index -> wb_data.
  - Otherwise -> rf_rdN.
- Immediate formats, all sign-extended from instr[31]:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH, bit0 = 0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL, bit0 = 0.
  - R-type and unknown opcodes -> imm = 0.
- Source usage:
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH.
  - Unknown opcode: uses neither, reg_write = 0.
- reg_write: opcode in {OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR} and rd != 0.
- load_use = if_valid && ex_valid && ex_is_load && ex_rd != 0 && ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd)).
- id_stall = !flush && (ex_stall || load_use).
- ID/EX update priority, per clock:
  1. reset: clear all outputs.
  2. flush: load a bubble (ex_valid = 0, ex_reg_write = 0, ex_is_load = 0, other fields don't-care/0). Flush wins over ex_stall.
  3. ex_stall: hold all ex_* unchanged.
  4. load_use: load a bubble. IF/ID holds via id_stall; the load advances, and the next cycle load_use clears.
  5. otherwise: load decoded fields, ex_valid = if_valid. When if_valid = 0, reg_write/is_load are forced to 0.
- While IF/ID is held, the register file is re-read every cycle and the bypass is re-applied, so operands captured on release reflect writebacks during the hold.
- Writeback to x0: no bypass; the operand reads 0.

Decomposition:
- Package core_pkg:
  - opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - enum imm_type_t: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE.
- Sub-module imm_gen: purely combinational, (instr, imm_type_t) -> WIDTH immediate.

Test Plan:
- Reset: assert reset with a valid ADDI in IF/ID -> all ex_* = 0 next cycle; after release, one cycle later ex_valid = 1.
- ADDI x5,x1,-3 (0xFFD08293), rf_rd1 = 10 -> ex_rs1_val = 10, ex_imm = 0xFFFFFFFD, ex_rd = 5, ex_reg_write = 1.
- Bypass: instr uses rs1 = x7, rf_rd1 = 1, wb_we = 1, wb_rd = 7, wb_data = 0xAB -> ex_rs1_val = 0xAB. Same case with wb_rd = 0 and rs1 = x0 -> ex_rs1_val = 0.
- Load-use: LW x3,0(x2) in EX, then ADD x4,x3,x1 in ID -> id_stall = 1 for one cycle, bubble loaded (ex_valid = 0), ADD issued the following cycle. LUI x3 in ID instead -> no stall.
- Stall/flush: ex_stall = 1 for 3 cycles -> ex_* unchanged and id_stall = 1. ex_stall = 1 with flush = 1 -> ex_valid = 0 next cycle and id_stall = 0.
- Immediates: BEQ with imm = -4096, SW offset 2047, JAL imm = +2 -> ex_imm = 0xFFFFF000, 0x000007FF, 0x00000002.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode map, immediate formats and the
// per-opcode control summary used by the ID stage.
package core_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_t;

    typedef struct packed {
        imm_type_t imm_type;
        logic      uses_rs1;
        logic      uses_rs2;
        logic      writes_rd;
        logic      is_load;
    } ctrl_t;

    // writes_rd ignores rd == x0; the stage qualifies it with the rd field.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '{imm_type: IMM_NONE, uses_rs1: 1'b0, uses_rs2: 1'b0,
              writes_rd: 1'b0, is_load: 1'b0};
        case (opcode)
            OP:      c = '{imm_type: IMM_NONE, uses_rs1: 1'b1, uses_rs2: 1'b1,
                           writes_rd: 1'b1, is_load: 1'b0};
            OP_IMM:  c = '{imm_type: IMM_I, uses_rs1: 1'b1, uses_rs2: 1'b0,
                           writes_rd: 1'b1, is_load: 1'b0};
            LOAD:    c = '{imm_type: IMM_I, uses_rs1: 1'b1, uses_rs2: 1'b0,
                           writes_rd: 1'b1, is_load: 1'b1};
            STORE:   c = '{imm_type: IMM_S, uses_rs1: 1'b1, uses_rs2: 1'b1,
                           writes_rd: 1'b0, is_load: 1'b0};
            BRANCH:  c = '{imm_type: IMM_B, uses_rs1: 1'b1, uses_rs2: 1'b1,
                           writes_rd: 1'b0, is_load: 1'b0};
            JAL:     c = '{imm_type: IMM_J, uses_rs1: 1'b0, uses_rs2: 1'b0,
                           writes_rd: 1'b1, is_load: 1'b0};
            JALR:    c = '{imm_type: IMM_I, uses_rs1: 1'b1, uses_rs2: 1'b0,
                           writes_rd: 1'b1, is_load: 1'b0};
            LUI:     c = '{imm_type: IMM_U, uses_rs1: 1'b0, uses_rs2: 1'b0,
                           writes_rd: 1'b1, is_load: 1'b0};
            AUIPC:   c = '{imm_type: IMM_U, uses_rs1: 1'b0, uses_rs2: 1'b0,
                           writes_rd: 1'b1, is_load: 1'b0};
            default: c = '{imm_type: IMM_NONE, uses_rs1: 1'b0, uses_rs2: 1'b0,
                           writes_rd: 1'b0, is_load: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX boundary: the registered decode bundle towards execute plus the
// execute-side back-pressure and squash controls.
interface decode_stage_if #(
    parameter int WIDTH     = 32,
    parameter int REGISTERS = 32
);
    localparam int AW = $clog2(REGISTERS);

    logic             ex_valid;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_rs1_val;
    logic [WIDTH-1:0] ex_rs2_val;
    logic [WIDTH-1:0] ex_imm;
    logic [AW-1:0]    ex_rs1;
    logic [AW-1:0]    ex_rs2;
    logic [AW-1:0]    ex_rd;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic             ex_is_load;
    logic             ex_reg_write;
    logic             ex_stall;
    logic             flush;

    modport master (
        output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
               ex_is_load, ex_reg_write,
        input  ex_stall, flush
    );

    modport slave (
        input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
               ex_is_load, ex_reg_write,
        output ex_stall, flush
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate builder; opcode bits are not needed, so only
// instr[31:7] enters.
module imm_gen
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:7]      instr_i,
    input  imm_type_t        imm_type_i,
    output logic [WIDTH-1:0] imm_o
);

    logic [31:0] imm32_s;

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (imm_type_i)
            IMM_I:   imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32_s = {instr_i[31:12], 12'h000};
            IMM_J:   imm32_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            default: imm32_s = 32'h0000_0000;
        endcase
    end

    assign imm_o = WIDTH'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: register-file addressing with same-cycle writeback bypass,
// field/immediate decode, load-use detection and the ID/EX pipeline register.
module decode_stage
    import core_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REGISTERS = 32,
    localparam int AW       = $clog2(REGISTERS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [WIDTH-1:0] if_pc,
    output logic [AW-1:0]    rf_a1,
    output logic [AW-1:0]    rf_a2,
    input  logic [WIDTH-1:0] rf_rd1,
    input  logic [WIDTH-1:0] rf_rd2,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             id_stall,
    decode_stage_if.master   ex_if
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] rs1_val;
        logic [WIDTH-1:0] rs2_val;
        logic [WIDTH-1:0] imm;
        logic [AW-1:0]    rs1;
        logic [AW-1:0]    rs2;
        logic [AW-1:0]    rd;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7b5;
        logic             is_load;
        logic             reg_write;
    } idex_t;

    idex_t            idex_q;
    idex_t            idex_d;
    ctrl_t            ctrl_s;
    logic [6:0]       opcode_s;
    logic [AW-1:0]    rs1_s;
    logic [AW-1:0]    rs2_s;
    logic [AW-1:0]    rd_s;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] op1_s;
    logic [WIDTH-1:0] op2_s;
    logic             load_use_s;

    // The register file writes on the edge, so a same-cycle writeback must be
    // taken from the bypass; x0 always reads zero, even when written.
    function automatic logic [WIDTH-1:0] operand(
        input logic [AW-1:0]    idx,
        input logic [WIDTH-1:0] rf_val,
        input logic             we,
        input logic [AW-1:0]    wrd,
        input logic [WIDTH-1:0] wdata
    );
        logic [WIDTH-1:0] v;
        if (idx == '0) begin
            v = '0;
        end else if (we && (wrd == idx)) begin
            v = wdata;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    assign opcode_s = if_instr[6:0];
    assign rs1_s    = AW'(if_instr[19:15]);
    assign rs2_s    = AW'(if_instr[24:20]);
    assign rd_s     = AW'(if_instr[11:7]);
    assign ctrl_s   = decode_ctrl(opcode_s);
    assign rf_a1    = rs1_s;
    assign rf_a2    = rs2_s;
    assign op1_s    = operand(rs1_s, rf_rd1, wb_we, wb_rd, wb_data);
    assign op2_s    = operand(rs2_s, rf_rd2, wb_we, wb_rd, wb_data);

    imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr_i    (if_instr[31:7]),
        .imm_type_i (ctrl_s.imm_type),
        .imm_o      (imm_s)
    );

    assign load_use_s = if_valid && idex_q.valid && idex_q.is_load &&
                        (idex_q.rd != '0) &&
                        ((ctrl_s.uses_rs1 && (rs1_s == idex_q.rd)) ||
                         (ctrl_s.uses_rs2 && (rs2_s == idex_q.rd)));

    // A flush squashes the ID instruction, so IF/ID is free to move even if EX stalls.
    assign id_stall = !ex_if.flush && (ex_if.ex_stall || load_use_s);

    // Next ID/EX contents: flush > EX hold > load-use bubble > decoded instruction.
    always_comb begin
        idex_d = idex_q;
        if (ex_if.flush) begin
            idex_d = '0;
        end else if (ex_if.ex_stall) begin
            idex_d = idex_q;
        end else if (load_use_s) begin
            idex_d = '0;
        end else begin
            idex_d.valid     = if_valid;
            idex_d.pc        = if_pc;
            idex_d.rs1_val   = op1_s;
            idex_d.rs2_val   = op2_s;
            idex_d.imm       = imm_s;
            idex_d.rs1       = rs1_s;
            idex_d.rs2       = rs2_s;
            idex_d.rd        = rd_s;
            idex_d.opcode    = opcode_s;
            idex_d.funct3    = if_instr[14:12];
            idex_d.funct7b5  = if_instr[30];
            idex_d.is_load   = if_valid && ctrl_s.is_load;
            idex_d.reg_write = if_valid && ctrl_s.writes_rd && (rd_s != '0);
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_if.ex_valid     = idex_q.valid;
    assign ex_if.ex_pc        = idex_q.pc;
    assign ex_if.ex_rs1_val   = idex_q.rs1_val;
    assign ex_if.ex_rs2_val   = idex_q.rs2_val;
    assign ex_if.ex_imm       = idex_q.imm;
    assign ex_if.ex_rs1       = idex_q.rs1;
    assign ex_if.ex_rs2       = idex_q.rs2;
    assign ex_if.ex_rd        = idex_q.rd;
    assign ex_if.ex_opcode    = idex_q.opcode;
    assign ex_if.ex_funct3    = idex_q.funct3;
    assign ex_if.ex_funct7b5  = idex_q.funct7b5;
    assign ex_if.ex_is_load   = idex_q.is_load;
    assign ex_if.ex_reg_write = idex_q.reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: the driver queues the expected ID/EX
// contents for every cycle and a monitor compares them after each edge.
module tb_decode_stage;
    import core_pkg::*;

    typedef struct packed {
        logic        full;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ld;
        logic        rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_stall;

    int checks   = 0;
    int failures = 0;

    exp_t  sb_q[$];
    string name_q[$];
    exp_t  mon_exp;
    exp_t  mon_act;
    string mon_name;
    exp_t  held;

    decode_stage_if #(.WIDTH(32), .REGISTERS(32)) exb ();

    decode_stage #(.WIDTH(32), .REGISTERS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .rf_a1    (rf_a1),
        .rf_a2    (rf_a2),
        .rf_rd1   (rf_rd1),
        .rf_rd2   (rf_rd2),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .id_stall (id_stall),
        .ex_if    (exb)
    );

    always #5 clk = ~clk;

    function automatic exp_t rec(input logic [31:0] pc, input logic [31:0] rs1v,
                                 input logic [31:0] rs2v, input logic [31:0] imm,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7b5,
                                 input logic ld, input logic rw);
        exp_t e;
        e = '{full: 1'b1, valid: 1'b1, pc: pc, rs1v: rs1v, rs2v: rs2v, imm: imm,
              rs1: rs1, rs2: rs2, rd: rd, op: op, f3: f3, f7b5: f7b5, ld: ld, rw: rw};
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                         input logic st, input logic fl);
        if_valid     = v;
        if_instr     = instr;
        if_pc        = pc;
        rf_rd1       = rd1;
        rf_rd2       = rd2;
        wb_we        = we;
        wb_rd        = wrd;
        wb_data      = wdata;
        exb.ex_stall = st;
        exb.flush    = fl;
    endtask

    task automatic tick(input string nm, input logic exp_stall, input exp_t e);
        #1;
        checks++;
        if (id_stall !== exp_stall) begin
            failures++;
            $display("FAIL %s id_stall: got %b expected %b", nm, id_stall, exp_stall);
        end
        sb_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: every edge produces one ID/EX state, checked against the queue.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_exp  = sb_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = '{full: mon_exp.full, valid: exb.ex_valid, pc: exb.ex_pc,
                         rs1v: exb.ex_rs1_val, rs2v: exb.ex_rs2_val, imm: exb.ex_imm,
                         rs1: exb.ex_rs1, rs2: exb.ex_rs2, rd: exb.ex_rd,
                         op: exb.ex_opcode, f3: exb.ex_funct3, f7b5: exb.ex_funct7b5,
                         ld: exb.ex_is_load, rw: exb.ex_reg_write};
            checks++;
            if (mon_exp.full ? (mon_act !== mon_exp)
                             : ({mon_act.valid, mon_act.ld, mon_act.rw} !==
                                {mon_exp.valid, mon_exp.ld, mon_exp.rw})) begin
                failures++;
                $display("FAIL %s idex: got %h expected %h", mon_name, mon_act, mon_exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 32'hFFD0_8293, 32'h0000_0100, 32'd10, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held with a valid ADDI in IF/ID: everything cleared, full compare.
        held = bub();
        held.full = 1'b1;
        tick("reset", 1'b0, held);
        reset = 1'b0;

        // ADDI x5,x1,-3
        drive(1'b1, 32'hFFD0_8293, 32'h0000_0100, 32'd10, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("addi", 1'b0, rec(32'h100, 32'd10, 32'h55, 32'hFFFF_FFFD, 5'd1, 5'd29, 5'd5,
                              7'h13, 3'd0, 1'b1, 1'b0, 1'b1));
        // ADDI x6,x7,1 with same-cycle writeback to x7
        drive(1'b1, 32'h0013_8313, 32'h0000_0104, 32'd1, 32'h22, 1'b1, 5'd7, 32'hAB, 1'b0, 1'b0);
        tick("bypass", 1'b0, rec(32'h104, 32'hAB, 32'h22, 32'd1, 5'd7, 5'd1, 5'd6,
                                7'h13, 3'd0, 1'b0, 1'b0, 1'b1));
        // ADDI x6,x0,1 with writeback to x0: operand stays 0
        drive(1'b1, 32'h0010_0313, 32'h0000_0108, 32'd5, 32'h33, 1'b1, 5'd0, 32'hAB, 1'b0, 1'b0);
        tick("bypass_x0", 1'b0, rec(32'h108, 32'd0, 32'h33, 32'd1, 5'd0, 5'd1, 5'd6,
                                   7'h13, 3'd0, 1'b0, 1'b0, 1'b1));
        // LW x3,0(x2)
        drive(1'b1, 32'h0001_2183, 32'h0000_010C, 32'h1000, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("lw", 1'b0, rec(32'h10C, 32'h1000, 32'd0, 32'd0, 5'd2, 5'd0, 5'd3,
                            7'h03, 3'd2, 1'b0, 1'b1, 1'b1));
        // ADD x4,x3,x1 right behind the load: stall one cycle, bubble
        drive(1'b1, 32'h0011_8233, 32'h0000_0110, 32'h77, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("load_use", 1'b1, bub());
        // Held ADD re-read with new rf data and an x1 writeback during the hold
        drive(1'b1, 32'h0011_8233, 32'h0000_0110, 32'h99, 32'h88, 1'b1, 5'd1, 32'h1234, 1'b0, 1'b0);
        tick("add_release", 1'b0, rec(32'h110, 32'h99, 32'h1234, 32'd0, 5'd3, 5'd1, 5'd4,
                                     7'h33, 3'd0, 1'b0, 1'b0, 1'b1));
        drive(1'b1, 32'h0001_2183, 32'h0000_0114, 32'h2000, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("lw2", 1'b0, rec(32'h114, 32'h2000, 32'd0, 32'd0, 5'd2, 5'd0, 5'd3,
                             7'h03, 3'd2, 1'b0, 1'b1, 1'b1));
        // LUI x3 after LW x3: rs2 field is 3 but LUI reads no sources
        held = rec(32'h118, 32'h11, 32'h22, 32'h1234_5000, 5'd8, 5'd3, 5'd3,
                   7'h37, 3'd5, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h1234_51B7, 32'h0000_0118, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("lui_no_stall", 1'b0, held);
        // Execute stall for three cycles: ID/EX frozen
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_0063, 32'h0000_011C, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
            tick("ex_stall_hold", 1'b1, held);
        end
        // Flush overrides the stall
        drive(1'b1, 32'h8000_0063, 32'h0000_011C, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        tick("flush_over_stall", 1'b0, bub());
        // BEQ x0,x0,-4096
        drive(1'b1, 32'h8000_0063, 32'h0000_0120, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("beq_imm", 1'b0, rec(32'h120, 32'd0, 32'd0, 32'hFFFF_F000, 5'd0, 5'd0, 5'd0,
                                 7'h63, 3'd0, 1'b0, 1'b0, 1'b0));
        // SW x2,2047(x1)
        drive(1'b1, 32'h7E20_AFA3, 32'h0000_0124, 32'h40, 32'h50, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("sw_imm", 1'b0, rec(32'h124, 32'h40, 32'h50, 32'h0000_07FF, 5'd1, 5'd2, 5'd31,
                                7'h23, 3'd2, 1'b1, 1'b0, 1'b0));
        // JAL x1,+2
        drive(1'b1, 32'h0020_00EF, 32'h0000_0128, 32'h60, 32'h70, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("jal_imm", 1'b0, rec(32'h128, 32'd0, 32'h70, 32'd2, 5'd0, 5'd2, 5'd1,
                                 7'h6F, 3'd0, 1'b0, 1'b0, 1'b1));
        // Invalid slot carrying a load encoding: no reg_write, no is_load
        drive(1'b0, 32'h0001_2183, 32'h0000_012C, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick("invalid_slot", 1'b0, bub());
        // Plain flush of a valid ADDI
        drive(1'b1, 32'hFFD0_8293, 32'h0000_0130, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        tick("flush", 1'b0, bub());

        drive(1'b0, 32'h0000_0013, 32'h0000_0134, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
